mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// ROM-to-RAM copy engine with a per-word data transform (pass, bit-reverse, half-swap, interleave).
// Optional read-back verify pass is enabled by defining MEM_COPY_VERIFY_EN.
module mem_copy_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs_n,
  output logic              rom_oe,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs_n,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   err_cnt
);

`ifdef MEM_COPY_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_VRD  = 3'd3,
    S_VCMP = 3'd4,
    S_DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd5
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Word transform selected by mode.
  function automatic logic [DATA_W-1:0] xform(input logic [1:0] m, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      2'b00: r = d;
      2'b01: begin
        for (int i = 0; i < DATA_W; i++) begin
          r[i] = d[DATA_W-1-i];
        end
      end
      2'b10: r = {d[DATA_W/2-1:0], d[DATA_W-1:DATA_W/2]};
      2'b11: begin
        for (int k = 0; k < DATA_W/2; k++) begin
          r[DATA_W-1-2*k] = d[k];
          r[DATA_W-2-2*k] = d[DATA_W-1-k];
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cur;
  logic [ADDR_W-1:0]   w_cur_next;
  logic [ADDR_W-1:0]   r_last;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rom_en;
  logic                r_ram_en;
  logic                r_ram_oe;
  logic                r_ram_we;
  logic                r_busy;
  logic                r_done;

`ifdef MEM_COPY_VERIFY_EN
  logic [ADDR_W-1:0]   r_first;
  logic [DATA_W-1:0]   r_rom_q;
  logic [DATA_W-1:0]   r_ram_q;
  logic                r_err;
  logic [ADDR_W:0]     r_err_cnt;
`endif

  // Next-state and next-address decode.
  always_comb begin
    w_next     = r_state;
    w_cur_next = r_cur;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next     = S_RD;
          w_cur_next = first_addr;
        end else begin
          w_next     = S_IDLE;
        end
      end
      S_RD: begin
        w_next = S_WR;
      end
      S_WR: begin
        if (r_cur == r_last) begin
`ifdef MEM_COPY_VERIFY_EN
          w_next     = S_VRD;
          w_cur_next = r_first;
`else
          w_next     = S_DONE;
`endif
        end else begin
          w_next     = S_RD;
          w_cur_next = r_cur + ADDR_ONE;
        end
      end
`ifdef MEM_COPY_VERIFY_EN
      S_VRD: begin
        w_next = S_VCMP;
      end
      S_VCMP: begin
        if (r_cur == r_last) begin
          w_next = S_DONE;
        end else begin
          w_next     = S_VRD;
          w_cur_next = r_cur + ADDR_ONE;
        end
      end
`endif
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, address and registered memory strobes derived from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cur    <= {ADDR_W{1'b0}};
      r_rom_en <= 1'b0;
      r_ram_en <= 1'b0;
      r_ram_oe <= 1'b0;
      r_ram_we <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cur    <= w_cur_next;
`ifdef MEM_COPY_VERIFY_EN
      r_rom_en <= (w_next == S_RD) || (w_next == S_VRD);
      r_ram_en <= (w_next == S_WR) || (w_next == S_VRD);
      r_ram_oe <= (w_next == S_VRD);
`else
      r_rom_en <= (w_next == S_RD);
      r_ram_en <= (w_next == S_WR);
      r_ram_oe <= 1'b0;
`endif
      r_ram_we <= (w_next == S_WR);
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (w_next == S_DONE);
    end
  end

  // Copy parameters latched on start acceptance; write data captured at the end of RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= {ADDR_W{1'b0}};
      r_mode  <= 2'b00;
      r_wdata <= {DATA_W{1'b0}};
    end else begin
      if (r_state == S_IDLE && start) begin
        r_last <= last_addr;
        r_mode <= mode;
      end
      if (r_state == S_RD) begin
        r_wdata <= xform(r_mode, rom_data);
      end
    end
  end

`ifdef MEM_COPY_VERIFY_EN
  // Read-back capture and compare; err/err_cnt cleared on each new copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first   <= {ADDR_W{1'b0}};
      r_rom_q   <= {DATA_W{1'b0}};
      r_ram_q   <= {DATA_W{1'b0}};
      r_err     <= 1'b0;
      r_err_cnt <= {(ADDR_W+1){1'b0}};
    end else begin
      if (r_state == S_IDLE && start) begin
        r_first   <= first_addr;
        r_err     <= 1'b0;
        r_err_cnt <= {(ADDR_W+1){1'b0}};
      end else if (r_state == S_VRD) begin
        r_rom_q <= xform(r_mode, rom_data);
        r_ram_q <= ram_rdata;
      end else if (r_state == S_VCMP && r_ram_q != r_rom_q) begin
        r_err <= 1'b1;
        if (r_err_cnt != {(ADDR_W+1){1'b1}}) begin
          r_err_cnt <= r_err_cnt + {{ADDR_W{1'b0}}, 1'b1};
        end
      end
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^ram_rdata;
  assign err            = 1'b0;
  assign err_cnt        = {(ADDR_W+1){1'b0}};
`endif

  assign rom_addr  = r_cur;
  assign ram_addr  = r_cur;
  assign rom_cs_n  = ~r_rom_en;
  assign rom_oe    = r_rom_en;
  assign ram_cs_n  = ~r_ram_en;
  assign ram_oe    = r_ram_oe;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized self-checking bench for mem_copy_engine (DATA_W=8, ADDR_W=5) against an array-based copy model.
module tb_mem_copy_engine;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk, rst, start;
  logic [AW-1:0] first_addr, last_addr;
  logic [1:0]    mode;
  logic [AW-1:0] rom_addr, ram_addr;
  logic          rom_cs_n, rom_oe, ram_cs_n, ram_oe, ram_we;
  logic [DW-1:0] rom_data, ram_wdata, ram_rdata;
  logic          busy, done, err;
  logic [AW:0]   err_cnt;

  logic [DW-1:0] rom [DEPTH];
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] exp_ram [DEPTH];
  int            wr_log[$];
  logic          fill_en, corrupt_en;
  int            n_tests = 0;
  int            n_fail  = 0;

  mem_copy_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .mode(mode), .rom_addr(rom_addr), .rom_cs_n(rom_cs_n), .rom_oe(rom_oe), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_cs_n(ram_cs_n), .ram_oe(ram_oe), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .done(done), .err(err),
    .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign rom_data  = rom[rom_addr];
  assign ram_rdata = ram[ram_addr] ^ ((corrupt_en && ram_addr == 5'd6) ? 8'h01 : 8'h00);

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'hA5 ^ 8'(i);
    end else if (!ram_cs_n && ram_we) begin
      ram[ram_addr] <= ram_wdata;
      wr_log.push_back(int'(ram_addr));
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] t_ref(input logic [1:0] m, input logic [7:0] d);
    logic [7:0] o;
    o = 8'h00;
    case (m)
      2'd0: o = d;
      2'd1: for (int i = 0; i < 8; i++) if (d[i]) o = o | (8'h80 >> i);
      2'd2: o = {d[3:0], d[7:4]};
      default: begin
        for (int k = 0; k < 4; k++) begin
          if (d[k])   o = o | (8'h80 >> (2*k));
          if (d[7-k]) o = o | (8'h40 >> (2*k));
        end
      end
    endcase
    return o;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " busy"},      32'(busy),      32'd0);
    check_eq({tag, " done"},      32'(done),      32'd0);
    check_eq({tag, " err"},       32'(err),       32'd0);
    check_eq({tag, " err_cnt"},   32'(err_cnt),   32'd0);
    check_eq({tag, " rom_cs_n"},  32'(rom_cs_n),  32'd1);
    check_eq({tag, " ram_cs_n"},  32'(ram_cs_n),  32'd1);
    check_eq({tag, " rom_oe"},    32'(rom_oe),    32'd0);
    check_eq({tag, " ram_oe"},    32'(ram_oe),    32'd0);
    check_eq({tag, " ram_we"},    32'(ram_we),    32'd0);
    check_eq({tag, " rom_addr"},  32'(rom_addr),  32'd0);
    check_eq({tag, " ram_addr"},  32'(ram_addr),  32'd0);
    check_eq({tag, " ram_wdata"}, 32'(ram_wdata), 32'd0);
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < DEPTH; a++) check_eq($sformatf("%s ram[%0d]", tag, a), 32'(ram[a]), 32'(exp_ram[a]));
  endtask

  // One full copy: model expected writes, run DUT, compare latency, write order, RAM and flags.
  task automatic run_copy(input string tag, input int f, input int l, input logic [1:0] m, input bit inject);
    int n, lat, cyc, addr, exp_cnt;
    int exp_wr[$];
    bit got_done;
    n = ((l - f) % DEPTH + DEPTH) % DEPTH + 1;
    exp_cnt = 0;
    for (int i = 0; i < n; i++) begin
      addr = (f + i) % DEPTH;
      exp_wr.push_back(addr);
      exp_ram[addr] = t_ref(m, rom[addr]);
      if (corrupt_en && addr == 6) exp_cnt++;
    end
`ifdef MEM_COPY_VERIFY_EN
    lat = 4*n + 1;
`else
    lat = 2*n + 1;
    exp_cnt = 0;
`endif
    @(negedge clk);
    wr_log.delete();
    first_addr = AW'(f);
    last_addr  = AW'(l);
    mode       = m;
    start      = 1'b1;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (inject && (cyc == 3 || cyc == 4)) begin
        start      = 1'b1;
        first_addr = AW'($urandom);
        last_addr  = AW'($urandom);
        mode       = 2'($urandom);
      end
      check_eq({tag, " we_oe_excl"}, 32'(ram_we & ram_oe), 32'd0);
      if (done) got_done = 1'b1;
      else check_eq({tag, " busy"}, 32'(busy), 32'd1);
    end
    start = 1'b0;
    check_eq({tag, " done_seen"}, 32'(got_done), 32'd1);
    check_eq({tag, " latency"}, 32'(cyc), 32'(lat));
    check_eq({tag, " busy_at_done"}, 32'(busy), 32'd1);
    check_eq({tag, " err"}, 32'(err), 32'(exp_cnt != 0));
    check_eq({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    @(negedge clk);
    check_eq({tag, " done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, " idle"}, 32'(busy), 32'd0);
    check_eq({tag, " nwrites"}, 32'(wr_log.size()), 32'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++)
      check_eq($sformatf("%s wr_order[%0d]", tag, i), 32'(wr_log[i]), 32'(exp_wr[i]));
    check_ram(tag);
  endtask

  initial begin
    int f, l, cyc;
    rst = 1'b1; start = 1'b0; fill_en = 1'b1; corrupt_en = 1'b0;
    first_addr = '0; last_addr = '0; mode = 2'b00;
    for (int i = 0; i < DEPTH; i++) exp_ram[i] = 8'hA5 ^ 8'(i);
    repeat (3) @(negedge clk);
    fill_en = 1'b0;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Identity ROM, interleave, 28 words.
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'(i);
    run_copy("ident_il", 4, 31, 2'b11, 1'b0);
    check_eq("il ram[4]", 32'(ram[4]), 32'h08);

    for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
    rom[4] = 8'h01;
    run_copy("single", 4, 4, 2'b01, 1'b0);
    check_eq("single ram[4]", 32'(ram[4]), 32'h80);

    rom[30] = 8'h3C;
    run_copy("wrap", 30, 1, 2'b10, 1'b0);
    check_eq("wrap ram[30]", 32'(ram[30]), 32'hC3);

    run_copy("busy_start", 2, 9, 2'($urandom), 1'b1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
      run_copy($sformatf("rand%0d", t), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               2'($urandom), 1'b0);
    end

    // Reset during the write cycle of the third word.
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
    mode = 2'($urandom);
    exp_ram[0] = t_ref(mode, rom[0]);
    exp_ram[1] = t_ref(mode, rom[1]);
    @(negedge clk);
    wr_log.delete();
    first_addr = 5'd0; last_addr = 5'd10; start = 1'b1;
    cyc = 0;
    while (cyc < 6) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    check_eq("pre_rst we", 32'(ram_we), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("midrst nwrites", 32'(wr_log.size()), 32'd2);
    check_eq("midrst idle", 32'(busy), 32'd0);
    check_ram("midrst");

    run_copy("after_rst", 20, 23, 2'b01, 1'b0);

`ifdef MEM_COPY_VERIFY_EN
    corrupt_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
    run_copy("verify_bad", 0, 10, 2'($urandom), 1'b0);
    corrupt_en = 1'b0;
    run_copy("verify_ok", 0, 10, 2'($urandom), 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
